// File: rtl/control_alucontrol_pkg.sv
// Shared decode constants for the ID-stage control unit: opcodes,
// ALU operation classes, final ALU codes and data-memory geometry.
package control_alucontrol_pkg;

    localparam int DATA_W    = 64;
    localparam int MEM_DEPTH = 32;
    localparam int IDX_W     = 5;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_HALT = 7'b1111111;

    typedef enum logic [1:0] {
        ALUOP_LDST  = 2'b00,
        ALUOP_BEQ   = 2'b01,
        ALUOP_RTYPE = 2'b10
    } aluop_t;

    typedef enum logic [3:0] {
        ALUCTR_AND = 4'b0000,
        ALUCTR_OR  = 4'b0001,
        ALUCTR_ADD = 4'b0010,
        ALUCTR_SUB = 4'b0110
    } aluctr_t;

    // Second-level ALU decode: class plus {funct7[5], funct3} for R-type.
    function automatic aluctr_t alu_ctr(input aluop_t op, input logic f7b5,
                                        input logic [2:0] f3);
        aluctr_t r;
        r = ALUCTR_AND;
        case (op)
            ALUOP_LDST: r = ALUCTR_ADD;
            ALUOP_BEQ:  r = ALUCTR_SUB;
            ALUOP_RTYPE: begin
                case ({f7b5, f3})
                    4'b0000: r = ALUCTR_ADD;
                    4'b1000: r = ALUCTR_SUB;
                    4'b0111: r = ALUCTR_AND;
                    4'b0110: r = ALUCTR_OR;
                    default: r = ALUCTR_AND;
                endcase
            end
            default: r = ALUCTR_AND;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/control_alucontrol_if.sv
// Bundle of the pipeline-register signals seen by the control unit:
// the IF/ID instruction, ID/EX hazard inputs, EX/MEM memory strobes,
// and the decoded controls, stall and memory read data it returns.
interface control_alucontrol_if;
    import control_alucontrol_pkg::*;

    logic [31:0]       instruction;
    logic              ex_memread;
    logic [4:0]        ex_rd;
    logic [DATA_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_write;
    logic              mem_read;

    logic              ctrl_branch;
    logic              ctrl_memread;
    logic              ctrl_memtoreg;
    logic              ctrl_memwrite;
    logic              ctrl_alusrc;
    logic              ctrl_regwrite;
    logic [1:0]        ctrl_ALUop;
    logic [3:0]        ctrl_ALUctr;
    logic              stall;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output instruction, ex_memread, ex_rd, mem_address, mem_wdata,
               mem_write, mem_read,
        input  ctrl_branch, ctrl_memread, ctrl_memtoreg, ctrl_memwrite,
               ctrl_alusrc, ctrl_regwrite, ctrl_ALUop, ctrl_ALUctr, stall,
               mem_rdata
    );

    modport slave (
        input  instruction, ex_memread, ex_rd, mem_address, mem_wdata,
               mem_write, mem_read,
        output ctrl_branch, ctrl_memread, ctrl_memtoreg, ctrl_memwrite,
               ctrl_alusrc, ctrl_regwrite, ctrl_ALUop, ctrl_ALUctr, stall,
               mem_rdata
    );

endinterface

// File: rtl/control_alucontrol_data_memory.sv
// 32 x 64-bit data memory: synchronous write, combinational read,
// whole array cleared asynchronously by the active-low reset.
module data_memory
    import control_alucontrol_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  index,
    input  logic [DATA_W-1:0] wdata,
    input  logic              write,
    input  logic              read,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // Storage update; reset wins over a write landing on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (write) begin
            mem[index] <= wdata;
        end
    end

    // Read-before-write: a same-index write only shows after the edge.
    assign rdata = read ? mem[index] : '0;

endmodule

// File: rtl/control_alucontrol.sv
// ID-stage main decoder, ALU control, load-use hazard detection and the
// MEM-stage data memory for a five-stage RISC-V style pipeline.
module control_alucontrol
    import control_alucontrol_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    control_alucontrol_if.slave bus
);

    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       branch, memread, memtoreg, memwrite, alusrc, regwrite;
    logic       known_op;
    aluop_t     aluop;
    aluctr_t    aluctr;
    logic       hazard;
    logic       bubble;
    logic       unused_bits;

    assign opcode = bus.instruction[6:0];
    assign rs1    = bus.instruction[19:15];
    assign rs2    = bus.instruction[24:20];

    // Main decode from the opcode; unknown opcodes (halt included) give all zeros.
    always_comb begin
        branch   = 1'b0;
        memread  = 1'b0;
        memtoreg = 1'b0;
        memwrite = 1'b0;
        alusrc   = 1'b0;
        regwrite = 1'b0;
        aluop    = ALUOP_LDST;
        known_op = 1'b1;
        case (opcode)
            OP_R: begin
                regwrite = 1'b1;
                aluop    = ALUOP_RTYPE;
            end
            OP_LD: begin
                alusrc   = 1'b1;
                memread  = 1'b1;
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            OP_SD: begin
                alusrc   = 1'b1;
                memwrite = 1'b1;
            end
            OP_BEQ: begin
                branch = 1'b1;
                aluop  = ALUOP_BEQ;
            end
            OP_HALT: known_op = 1'b0;
            default: known_op = 1'b0;
        endcase
        aluctr = known_op ? alu_ctr(aluop, bus.instruction[30], bus.instruction[14:12])
                          : ALUCTR_AND;
    end

    // Load-use hazard: the load in EX targets a source register of the ID instruction.
    assign hazard = bus.ex_memread && (bus.ex_rd != 5'd0) &&
                    ((bus.ex_rd == rs1) || (bus.ex_rd == rs2));

    // A stall or a held reset turns the ID/EX controls into a bubble.
    assign bubble = hazard || !reset;

    assign bus.stall         = hazard && reset;
    assign bus.ctrl_branch   = branch   && !bubble;
    assign bus.ctrl_memread  = memread  && !bubble;
    assign bus.ctrl_memtoreg = memtoreg && !bubble;
    assign bus.ctrl_memwrite = memwrite && !bubble;
    assign bus.ctrl_alusrc   = alusrc   && !bubble;
    assign bus.ctrl_regwrite = regwrite && !bubble;
    assign bus.ctrl_ALUop    = bubble ? 2'b00   : aluop;
    assign bus.ctrl_ALUctr   = bubble ? 4'b0000 : aluctr;

    // Address bits outside [7:3] and instruction fields not used for decode.
    assign unused_bits = ^{bus.mem_address[DATA_W-1:8], bus.mem_address[2:0],
                           bus.instruction[31], bus.instruction[29:25],
                           bus.instruction[11:7]};

    data_memory u_data_memory (
        .clk   (clk),
        .reset (reset),
        .index (bus.mem_address[7:3]),
        .wdata (bus.mem_wdata),
        .write (bus.mem_write),
        .read  (bus.mem_read),
        .rdata (bus.mem_rdata)
    );

endmodule

// File: tb/tb_control_alucontrol.sv
// Bench for control_alucontrol: decode/hazard vector table plus
// hand-written memory and reset sequences, checked through a scoreboard.
module tb_control_alucontrol;
    import control_alucontrol_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    control_alucontrol_if bus ();

    control_alucontrol dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [63:0] exp;
    } sb_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        exmr;
        logic [4:0]  exrd;
        logic [12:0] exp;   // {branch,memread,memtoreg,memwrite,alusrc,regwrite,ALUop,ALUctr,stall}
    } dvec_t;

    sb_t   sbq[$];
    dvec_t tbl[15];
    int    total = 0;
    int    bad   = 0;

    function automatic logic [63:0] ctrl_vec();
        return {51'd0, bus.ctrl_branch, bus.ctrl_memread, bus.ctrl_memtoreg,
                bus.ctrl_memwrite, bus.ctrl_alusrc, bus.ctrl_regwrite,
                bus.ctrl_ALUop, bus.ctrl_ALUctr, bus.stall};
    endfunction

    task automatic expect_push(input string n, input logic [63:0] e);
        sb_t s;
        s.name = n;
        s.exp  = e;
        sbq.push_back(s);
    endtask

    task automatic check_pop(input logic [63:0] act);
        sb_t s;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty: got 0x%0h with no expectation", act);
        end else begin
            s = sbq.pop_front();
            if (act !== s.exp) begin
                bad++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", s.name, act, s.exp);
            end
        end
    endtask

    task automatic mem_drive(input logic wr, input logic rd,
                             input logic [63:0] addr, input logic [63:0] wd);
        bus.mem_write   = wr;
        bus.mem_read    = rd;
        bus.mem_address = addr;
        bus.mem_wdata   = wd;
    endtask

    initial begin
        tbl[0]  = '{"add",        32'h002081B3, 1'b0, 5'd0, 13'b0_0_0_0_0_1_10_0010_0};
        tbl[1]  = '{"sub",        32'h402081B3, 1'b0, 5'd0, 13'b0_0_0_0_0_1_10_0110_0};
        tbl[2]  = '{"and",        32'h0020F1B3, 1'b0, 5'd0, 13'b0_0_0_0_0_1_10_0000_0};
        tbl[3]  = '{"or",         32'h0020E1B3, 1'b0, 5'd0, 13'b0_0_0_0_0_1_10_0001_0};
        tbl[4]  = '{"xor_other",  32'h0020C1B3, 1'b0, 5'd0, 13'b0_0_0_0_0_1_10_0000_0};
        tbl[5]  = '{"f7_and",     32'h4020F1B3, 1'b0, 5'd0, 13'b0_0_0_0_0_1_10_0000_0};
        tbl[6]  = '{"ld",         32'h0000B183, 1'b0, 5'd0, 13'b0_1_1_0_1_1_00_0010_0};
        tbl[7]  = '{"sd",         32'h0020B023, 1'b0, 5'd0, 13'b0_0_0_1_1_0_00_0010_0};
        tbl[8]  = '{"beq",        32'h00208063, 1'b0, 5'd0, 13'b1_0_0_0_0_0_01_0110_0};
        tbl[9]  = '{"halt",       32'h0000007F, 1'b0, 5'd0, 13'b0_0_0_0_0_0_00_0000_0};
        tbl[10] = '{"stall_rs1",  32'h006281B3, 1'b1, 5'd5, 13'b0_0_0_0_0_0_00_0000_1};
        tbl[11] = '{"no_stall_x0",32'h006281B3, 1'b1, 5'd0, 13'b0_0_0_0_0_1_10_0010_0};
        tbl[12] = '{"no_stall_mr",32'h006281B3, 1'b0, 5'd5, 13'b0_0_0_0_0_1_10_0010_0};
        tbl[13] = '{"stall_rs2",  32'h006281B3, 1'b1, 5'd6, 13'b0_0_0_0_0_0_00_0000_1};
        tbl[14] = '{"no_stall_rd",32'h406281B3, 1'b1, 5'd7, 13'b0_0_0_0_0_1_10_0110_0};

        // Reset held: controls and stall silenced despite a live hazard.
        reset           = 1'b0;
        bus.instruction = 32'h006281B3;
        bus.ex_memread  = 1'b1;
        bus.ex_rd       = 5'd5;
        mem_drive(1'b0, 1'b1, 64'd16, 64'd0);
        #2;
        expect_push("reset_ctrl", 64'd0);
        check_pop(ctrl_vec());
        expect_push("reset_rdata", 64'd0);
        check_pop(bus.mem_rdata);

        @(negedge clk);
        reset = 1'b1;
        mem_drive(1'b0, 1'b0, 64'd0, 64'd0);

        // Decode and hazard table.
        for (int i = 0; i < 15; i++) begin
            bus.instruction = tbl[i].instr;
            bus.ex_memread  = tbl[i].exmr;
            bus.ex_rd       = tbl[i].exrd;
            #2;
            expect_push(tbl[i].name, {51'd0, tbl[i].exp});
            check_pop(ctrl_vec());
            @(negedge clk);
        end

        // Write 0xDEAD at address 16 (index 2), read back directly and via wrap.
        bus.instruction = 32'h0000007F;
        bus.ex_memread  = 1'b0;
        mem_drive(1'b1, 1'b0, 64'd16, 64'hDEAD);
        @(negedge clk);
        mem_drive(1'b0, 1'b1, 64'd16, 64'd0);
        #1;
        expect_push("rd_addr16", 64'hDEAD);
        check_pop(bus.mem_rdata);
        bus.mem_address = 64'd272;
        #1;
        expect_push("rd_wrap272", 64'hDEAD);
        check_pop(bus.mem_rdata);
        bus.mem_read = 1'b0;
        #1;
        expect_push("rd_disabled", 64'd0);
        check_pop(bus.mem_rdata);

        // Same-cycle write 7 and read of index 3: old value before the edge.
        @(negedge clk);
        mem_drive(1'b1, 1'b1, 64'd24, 64'd7);
        #1;
        expect_push("rw_before_edge", 64'd0);
        check_pop(bus.mem_rdata);
        @(posedge clk);
        #1;
        expect_push("rw_after_edge", 64'd7);
        check_pop(bus.mem_rdata);
        @(negedge clk);
        mem_drive(1'b0, 1'b1, 64'd27, 64'd0);
        #1;
        expect_push("rd_low_bits_ignored", 64'd7);
        check_pop(bus.mem_rdata);

        // Reset asserted mid-write: write to index 6 is discarded, array cleared.
        @(negedge clk);
        mem_drive(1'b1, 1'b0, 64'd48, 64'h99);
        bus.instruction = 32'h006281B3;
        bus.ex_memread  = 1'b1;
        bus.ex_rd       = 5'd5;
        reset           = 1'b0;
        #2;
        expect_push("reset_hazard_ctrl", 64'd0);
        check_pop(ctrl_vec());
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        bus.ex_memread = 1'b0;
        mem_drive(1'b0, 1'b1, 64'd0, 64'd0);
        for (int i = 0; i < MEM_DEPTH; i++) begin
            bus.mem_address = 64'(i * 8);
            #1;
            expect_push($sformatf("cleared_idx%0d", i), 64'd0);
            check_pop(bus.mem_rdata);
        end

        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sbq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
